clock_time_ctrl: RTL
====================

# clock_time_ctrl

Sequencing controller for the digital-clock digit chain. It owns the six BCD digit counters (sec/min/hour, ones and tens) and drives their count enables and clears from a 1 Hz tick. It implements the 59→00 and hour-wrap carry logic and a two-button time-set mode with blink-blanking for the display. It sits between the tick divider and key debouncers on one side and the digit counters and display mux on the other.

## Interface
- HOURS, 24, hour modulus; legal values 24 or 12. The hour display runs 00..HOURS-1.
- CP  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle 1 Hz pulse; consecutive pulses are at least 3 CP cycles apart.
- key_mode  in  1  debounced level from the mode button.
- key_inc  in  1  debounced level from the increment button.
- sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi  in  4 each  current digit counter values, BCD.
- en  out  6  count enables, one-cycle pulses. Bit order: [0] sec_lo, [1] sec_hi, [2] min_lo, [3] min_hi, [4] hr_lo, [5] hr_hi.
- clr_sec  out  1  one-cycle pulse that clears both seconds digits.
- clr_hr  out  1  one-cycle pulse that clears both hour digits.
- mode  out  2  0 = RUN, 1 = SET_HR, 2 = SET_MIN.
- blank_hr, blank_min  out  1 each  display blanking for the field being set.

## Operation
- Key edge detection: each key is registered and a rising edge is detected. The history register resets to 1, so a key held through reset release produces no edge.
- State machine:
  - RUN → SET_HR on a key_mode edge.
  - SET_HR → SET_MIN on a key_mode edge.
  - SET_MIN → RUN on a key_mode edge.
  - Encoding 3 is unreachable and recovers to RUN.
- Entering SET_HR pulses clr_sec. Seconds then stay at 00 until the block returns to RUN.
- RUN, on tick:
  - S59 = (sec == 59); M59 = (min == 59); HMAX = (hr == HOURS-1).
  - en[0] = 1.
  - en[1] = (sec_lo == 9).
  - en[2] = S59.
  - en[3] = S59 && (min_lo == 9).
  - en[4] = S59 && M59 && !HMAX.
  - en[5] = en[4] && (hr_lo == 9).
  - clr_hr = S59 && M59 && HMAX.
  - The seconds-tens and minutes-tens counters are modulo-6 and wrap on their own; this block never clears minutes.
- SET_HR, on a key_inc edge:
  - If HMAX: clr_hr, en = 0.
  - Otherwise: en[4] = 1 and en[5] = (hr_lo == 9).
- SET_MIN, on a key_inc edge:
  - en[2] = 1 and en[3] = (min_lo == 9).
  - 59 wraps to 00 with no carry into the hours.
- In the set states, tick never advances time. It only toggles blink_ph.
- blink_ph clears to 0 on every state change.
- blank_hr = (mode == SET_HR) && blink_ph; blank_min = (mode == SET_MIN) && blink_ph. Both are 0 in RUN.
- All arithmetic is compares on 4-bit BCD inputs. Input values above 9 are never produced by the counters; with such inputs, en and clr_hr behaviour is undefined.

## Timing
- Reset values: mode = RUN; en = 0; clr_sec = 0; clr_hr = 0; blink_ph = 0; blank_hr = 0; blank_min = 0; key history = 1.
- Latency: en, clr_hr and clr_sec are registered. They assert exactly one cycle after the cycle in which tick or the key edge is sampled, and last one cycle. Counters update on the edge that ends that cycle.
- Digit inputs are sampled in the same cycle as tick or the key edge.
- clr_hr and en[5:4] are never asserted together.
- A key_mode edge in the same cycle as tick: the tick is processed under the state held before the edge, and the state changes at that edge.
- A key_inc edge in the same cycle as tick in a set state: the increment is applied and blink_ph toggles.
- key_mode and key_inc edges in the same cycle: key_inc is processed under the current state, then the state advances.
- key_inc in RUN is ignored.
- Reset asserted mid-operation (any state, including a pulse in flight) forces the reset values immediately. No pulse completes.

## Structure
- Shared package clock_pkg:
  - mode codes MODE_RUN, MODE_SET_HR, MODE_SET_MIN.
  - en bit indices EN_SEC_LO..EN_HR_HI.
  - BCD constant DIGIT_MAX = 9.
- Sub-module key_edge: one instance per key. It holds the history register and produces a one-cycle rising-edge output.

## Test plan
- Reset, then digits 00:00:09 and one tick → en = 6'b000011 for exactly one cycle, one cycle after tick; clr_hr = 0.
- 09:59:59, tick → en = 6'b111111; clr_hr = 0.
- 23:59:59, tick (HOURS = 24) → en = 6'b001111 and clr_hr = 1 in the same cycle. Repeat with HOURS = 12 at 11:59:59 → same response.
- key_mode edge → mode = 1 and clr_sec pulses.
  - key_inc at hr 09 → en = 6'b110000.
  - key_inc at hr 23 → clr_hr = 1, en = 0.
  - tick → en = 0 and blank_hr toggles.
- mode = 2 at min 59, key_inc together with tick → en = 6'b001100 only; hours untouched. Then key_mode → mode = 0 and blank_min = 0.
- reset_n low in SET_MIN with key_inc held → all outputs at reset values. Release with key still held → no en pulse and mode = 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock sequencing controller.
package clock_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned EN_W    = 6;

    localparam int unsigned EN_SEC_LO = 0;
    localparam int unsigned EN_SEC_HI = 1;
    localparam int unsigned EN_MIN_LO = 2;
    localparam int unsigned EN_MIN_HI = 3;
    localparam int unsigned EN_HR_LO  = 4;
    localparam int unsigned EN_HR_HI  = 5;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    // True when a seconds or minutes field reads 59.
    function automatic logic is_59(input logic [DIGIT_W-1:0] hi, input logic [DIGIT_W-1:0] lo);
        return (hi == TENS_MAX) && (lo == DIGIT_MAX);
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for a debounced key; history resets high so a held key is not an edge.
module key_edge (
    input  logic CP,
    input  logic reset_n,
    input  logic key,
    output logic rise_c
);

    logic hist_d;
    logic hist_q;

    always_comb begin
        hist_d = key;
    end

    always_ff @(posedge CP or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rise_c = key & ~hist_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Digit-chain sequencer: carry logic on the 1 Hz tick plus the two-button time-set mode.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOURS = 24
) (
    input  logic               CP,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               key_mode,
    input  logic               key_inc,
    input  logic [DIGIT_W-1:0] sec_lo,
    input  logic [DIGIT_W-1:0] sec_hi,
    input  logic [DIGIT_W-1:0] min_lo,
    input  logic [DIGIT_W-1:0] min_hi,
    input  logic [DIGIT_W-1:0] hr_lo,
    input  logic [DIGIT_W-1:0] hr_hi,
    output logic [EN_W-1:0]    en,
    output logic               clr_sec,
    output logic               clr_hr,
    output logic [1:0]         mode,
    output logic               blank_hr,
    output logic               blank_min
);

    localparam logic [DIGIT_W-1:0] HR_MAX_HI = DIGIT_W'((HOURS - 1) / 10);
    localparam logic [DIGIT_W-1:0] HR_MAX_LO = DIGIT_W'((HOURS - 1) % 10);

    logic mode_rise_c;
    logic inc_rise_c;

    key_edge u_mode_edge (
        .CP      (CP),
        .reset_n (reset_n),
        .key     (key_mode),
        .rise_c  (mode_rise_c)
    );

    key_edge u_inc_edge (
        .CP      (CP),
        .reset_n (reset_n),
        .key     (key_inc),
        .rise_c  (inc_rise_c)
    );

    mode_e           mode_d,      mode_q;
    logic            blink_ph_d,  blink_ph_q;
    logic [EN_W-1:0] en_d,        en_q;
    logic            clr_sec_d,   clr_sec_q;
    logic            clr_hr_d,    clr_hr_q;
    logic            blank_hr_d,  blank_hr_q;
    logic            blank_min_d, blank_min_q;

    logic s59_c;
    logic m59_c;
    logic hmax_c;

    assign s59_c  = is_59(sec_hi, sec_lo);
    assign m59_c  = is_59(min_hi, min_lo);
    assign hmax_c = (hr_hi == HR_MAX_HI) && (hr_lo == HR_MAX_LO);

    // Next state, carry enables and clear pulses; key_inc/tick act under the current mode.
    always_comb begin
        mode_d     = mode_q;
        blink_ph_d = blink_ph_q;
        en_d       = '0;
        clr_sec_d  = 1'b0;
        clr_hr_d   = 1'b0;

        case (mode_q)
            MODE_RUN: begin
                if (tick) begin
                    en_d[EN_SEC_LO] = 1'b1;
                    en_d[EN_SEC_HI] = (sec_lo == DIGIT_MAX);
                    en_d[EN_MIN_LO] = s59_c;
                    en_d[EN_MIN_HI] = s59_c && (min_lo == DIGIT_MAX);
                    en_d[EN_HR_LO]  = s59_c && m59_c && !hmax_c;
                    en_d[EN_HR_HI]  = s59_c && m59_c && !hmax_c && (hr_lo == DIGIT_MAX);
                    clr_hr_d        = s59_c && m59_c && hmax_c;
                end
                if (mode_rise_c) begin
                    mode_d    = MODE_SET_HR;
                    clr_sec_d = 1'b1;
                end
            end
            MODE_SET_HR: begin
                if (inc_rise_c) begin
                    if (hmax_c) begin
                        clr_hr_d = 1'b1;
                    end else begin
                        en_d[EN_HR_LO] = 1'b1;
                        en_d[EN_HR_HI] = (hr_lo == DIGIT_MAX);
                    end
                end
                if (tick) begin
                    blink_ph_d = ~blink_ph_q;
                end
                if (mode_rise_c) begin
                    mode_d = MODE_SET_MIN;
                end
            end
            MODE_SET_MIN: begin
                // Minutes wrap on their own counters; no carry into hours here.
                if (inc_rise_c) begin
                    en_d[EN_MIN_LO] = 1'b1;
                    en_d[EN_MIN_HI] = (min_lo == DIGIT_MAX);
                end
                if (tick) begin
                    blink_ph_d = ~blink_ph_q;
                end
                if (mode_rise_c) begin
                    mode_d = MODE_RUN;
                end
            end
            default: begin
                mode_d = MODE_RUN;
            end
        endcase

        if (mode_d != mode_q) begin
            blink_ph_d = 1'b0;
        end

        blank_hr_d  = (mode_d == MODE_SET_HR)  && blink_ph_d;
        blank_min_d = (mode_d == MODE_SET_MIN) && blink_ph_d;
    end

    always_ff @(posedge CP or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= MODE_RUN;
            blink_ph_q  <= 1'b0;
            en_q        <= '0;
            clr_sec_q   <= 1'b0;
            clr_hr_q    <= 1'b0;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            blink_ph_q  <= blink_ph_d;
            en_q        <= en_d;
            clr_sec_q   <= clr_sec_d;
            clr_hr_q    <= clr_hr_d;
            blank_hr_q  <= blank_hr_d;
            blank_min_q <= blank_min_d;
        end
    end

    assign en        = en_q;
    assign clr_sec   = clr_sec_q;
    assign clr_hr    = clr_hr_q;
    assign mode      = mode_q;
    assign blank_hr  = blank_hr_q;
    assign blank_min = blank_min_q;

endmodule
